reg_file_mp: RTL and testbench
==============================

# reg_file_mp

Parametrised multi-port register file for the CPU datapath: configurable data width and depth, `N_RD` asynchronous read ports, two synchronous write ports with a fixed priority, optional same-cycle write-to-read bypass, and an optional hardwired-zero register 0. It also keeps a per-register busy scoreboard so the issue stage can stall on pending results. It sits between decode (read addresses, busy set) and writeback (two write ports).

## Interface
Parameters:
- `DATA_W`, 32, register width in bits
- `ADDR_W`, 5, address width; depth = 2^`ADDR_W`
- `N_RD`, 2, number of read ports (1..4)
- `ZERO_REG`, 1, 1 = register 0 always reads 0, and writes and busy sets to it are ignored
- `BYPASS`, 1, 1 = a read returns the data being written in the same cycle

Ports:
- `Clk` in 1: single clock, rising edge
- `Reset` in 1: synchronous, active-high
- `R_Addr` in `N_RD*ADDR_W`: read addresses; port k = bits [k*ADDR_W +: ADDR_W]
- `R_Data` out `N_RD*DATA_W`: read data, packed the same way as `R_Addr`
- `R_Busy` out `N_RD`: busy flag of the addressed register, one bit per read port
- `W_Addr_0`, `W_Addr_1` in `ADDR_W`: write addresses
- `Write_Reg_0`, `Write_Reg_1` in 1: write enables
- `W_Data_0`, `W_Data_1` in `DATA_W`: write data
- `Busy_Set` in 1: marks `Busy_Addr` as pending
- `Busy_Addr` in `ADDR_W`: register being reserved

## Operation
Storage and reset:
- Storage is 2^`ADDR_W` words of `DATA_W` bits plus one busy bit per register.
- `Reset`=1 at a rising edge clears every word and busy bit to 0. Reset overrides all writes and busy sets in that cycle.

Writes:
- A write occurs at the rising edge when `Write_Reg_x`=1.
- If both ports are enabled with the same address, port 1 wins.
- A write clears the busy bit of its address.

Busy scoreboard:
- `Busy_Set`=1 sets the busy bit of `Busy_Addr` at the edge.
- If a write clears and `Busy_Set` sets the same address in the same cycle, set wins (a new producer has issued). The written data is still stored.

Register 0 (`ZERO_REG`=1):
- Address 0 is never written and never marked busy.
- Reads of address 0 return 0 with `R_Busy`=0, bypass included.

Reads:
- Reads are combinational from `R_Addr`.
- With `BYPASS`=1, the read data mux has this priority: zero-reg, then port-1 write match, then port-0 write match, then storage.
- With `BYPASS`=1, `R_Busy` reads 0 when a same-cycle write targets that address, unless `Busy_Set` also targets it in that cycle.
- With `BYPASS`=0, reads reflect storage only; a value written at edge n is visible after edge n.
- While `Reset`=1 the read outputs still reflect storage and bypass; they show 0 after the reset edge.

## Timing
- Read latency: 0 cycles (combinational).
- Write latency: 1 edge; with `BYPASS`=1 the value is visible in the same cycle.
- Busy set or clear: takes effect at the edge and appears on `R_Busy` after the edge, except for the bypass rule above.
- Reset values: all `R_Data`=0 and all `R_Busy`=0 from the first edge with `Reset`=1 onward.
- No handshake: every operation completes in one cycle and the block never stalls.

## Structure
- A shared package `rf_pkg` holds the default `DATA_W`/`ADDR_W` and the helper function that slices the packed `R_Addr`/`R_Data` buses.
- One sub-module, `rf_read_port`, contains the per-port mux with zero-reg, bypass and busy logic. It is instantiated `N_RD` times in a generate loop.
- The storage and scoreboard arrays stay in the top module.

## Test plan
1. Reset, then write 0x11111111 to r1 via port 0 and 0x22222222 to r2 via port 1 on the same edge. Reading r1 and r2 returns those values with `R_Busy`=0. Assert `Reset`; after the edge both read 0.
2. Write 0xAAAA0000 to r5 via port 0 and 0x5555FFFF to r5 via port 1 on the same edge. r5 reads 0x5555FFFF.
3. `ZERO_REG`=1: write 0xDEADBEEF to r0 and assert `Busy_Set` on r0. r0 reads 0 with `R_Busy`=0, including in the write cycle.
4. `BYPASS`=1: while reading r7, write 0x12345678 to r7. `R_Data` shows 0x12345678 in the same cycle. With `BYPASS`=0 it shows the old value until after the edge.
5. `Busy_Set` on r3; after the edge `R_Busy`=1. A port-0 write to r3 clears busy after the next edge. A write to r3 with a simultaneous `Busy_Set` on r3 leaves busy=1 and stores the data.
6. `N_RD`=4: four ports read r1, r2, r3 and r0 simultaneously and each returns its own value, with no cross-port interference.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared defaults and bus-lane helper for the multi-port register file.
package rf_pkg;

    localparam int unsigned RF_DATA_W = 32;
    localparam int unsigned RF_ADDR_W = 5;

    // LSB of lane k in a bus packed as {lane[N-1], ..., lane[0]}
    function automatic int unsigned lane_lsb(input int unsigned k,
                                             input int unsigned w);
        return k * w;
    endfunction

endpackage

// File: rtl/rf_read_port.sv
// One asynchronous read port: zero-reg override, write bypass
// and busy-flag masking in front of the stored word.
module rf_read_port
    import rf_pkg::*;
#(
    parameter int unsigned DATA_W   = RF_DATA_W,
    parameter int unsigned ADDR_W   = RF_ADDR_W,
    parameter bit          ZERO_REG = 1'b1,
    parameter bit          BYPASS   = 1'b1
) (
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] store_data_i,
    input  logic              store_busy_i,
    input  logic              we0_i,
    input  logic [ADDR_W-1:0] wa0_i,
    input  logic [DATA_W-1:0] wd0_i,
    input  logic              we1_i,
    input  logic [ADDR_W-1:0] wa1_i,
    input  logic [DATA_W-1:0] wd1_i,
    input  logic              bset_i,
    input  logic [ADDR_W-1:0] baddr_i,
    output logic [DATA_W-1:0] data_o,
    output logic              busy_o
);

    logic hit0;
    logic hit1;
    logic bhit;

    assign hit0 = we0_i && (wa0_i == addr_i);
    assign hit1 = we1_i && (wa1_i == addr_i);
    assign bhit = bset_i && (baddr_i == addr_i);

    always_comb begin
        data_o = store_data_i;
        busy_o = store_busy_i;
        if (ZERO_REG && (addr_i == '0)) begin
            data_o = '0;
            busy_o = 1'b0;
        end else if (BYPASS) begin
            if (hit1) begin
                data_o = wd1_i;
            end else if (hit0) begin
                data_o = wd0_i;
            end
            // A new producer issuing this cycle keeps the register pending
            if ((hit0 || hit1) && !bhit) begin
                busy_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file with two prioritised write ports
// and a per-register busy scoreboard.
module reg_file_mp
    import rf_pkg::*;
#(
    parameter int unsigned DATA_W   = RF_DATA_W,
    parameter int unsigned ADDR_W   = RF_ADDR_W,
    parameter int unsigned N_RD     = 2,
    parameter bit          ZERO_REG = 1'b1,
    parameter bit          BYPASS   = 1'b1
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic [N_RD*ADDR_W-1:0]   R_Addr,
    output logic [N_RD*DATA_W-1:0]   R_Data,
    output logic [N_RD-1:0]          R_Busy,
    input  logic [ADDR_W-1:0]        W_Addr_0,
    input  logic [ADDR_W-1:0]        W_Addr_1,
    input  logic                     Write_Reg_0,
    input  logic                     Write_Reg_1,
    input  logic [DATA_W-1:0]        W_Data_0,
    input  logic [DATA_W-1:0]        W_Data_1,
    input  logic                     Busy_Set,
    input  logic [ADDR_W-1:0]        Busy_Addr
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0][DATA_W-1:0] mem_q;
    logic [DEPTH-1:0][DATA_W-1:0] mem_d;
    logic [DEPTH-1:0]             busy_q;
    logic [DEPTH-1:0]             busy_d;

    logic we0;
    logic we1;
    logic bset;

    assign we0  = Write_Reg_0 && !(ZERO_REG && (W_Addr_0 == '0));
    assign we1  = Write_Reg_1 && !(ZERO_REG && (W_Addr_1 == '0));
    assign bset = Busy_Set && !(ZERO_REG && (Busy_Addr == '0));

    // Port 1 applied after port 0 so it wins on an address clash;
    // busy set applied last so it beats the write-clear.
    always_comb begin
        mem_d  = mem_q;
        busy_d = busy_q;
        if (we0) begin
            mem_d[W_Addr_0]  = W_Data_0;
            busy_d[W_Addr_0] = 1'b0;
        end
        if (we1) begin
            mem_d[W_Addr_1]  = W_Data_1;
            busy_d[W_Addr_1] = 1'b0;
        end
        if (bset) begin
            busy_d[Busy_Addr] = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            mem_q  <= '0;
            busy_q <= '0;
        end else begin
            mem_q  <= mem_d;
            busy_q <= busy_d;
        end
    end

    for (genvar k = 0; k < N_RD; k++) begin : g_rd
        localparam int unsigned AL = lane_lsb(k, ADDR_W);
        localparam int unsigned DL = lane_lsb(k, DATA_W);

        logic [ADDR_W-1:0] ra;
        assign ra = R_Addr[AL +: ADDR_W];

        rf_read_port #(
            .DATA_W  (DATA_W),
            .ADDR_W  (ADDR_W),
            .ZERO_REG(ZERO_REG),
            .BYPASS  (BYPASS)
        ) u_port (
            .addr_i      (ra),
            .store_data_i(mem_q[ra]),
            .store_busy_i(busy_q[ra]),
            .we0_i       (we0),
            .wa0_i       (W_Addr_0),
            .wd0_i       (W_Data_0),
            .we1_i       (we1),
            .wa1_i       (W_Addr_1),
            .wd1_i       (W_Data_1),
            .bset_i      (bset),
            .baddr_i     (Busy_Addr),
            .data_o      (R_Data[DL +: DATA_W]),
            .busy_o      (R_Busy[k])
        );
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: a bypassing and a non-bypassing instance
// share all inputs; expectations go through a scoreboard queue.
module tb_reg_file_mp;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 4;

    logic             Clk;
    logic             Reset;
    logic [NR*AW-1:0] R_Addr;
    logic [NR*DW-1:0] rdata_a;
    logic [NR*DW-1:0] rdata_b;
    logic [NR-1:0]    rbusy_a;
    logic [NR-1:0]    rbusy_b;
    logic [AW-1:0]    W_Addr_0;
    logic [AW-1:0]    W_Addr_1;
    logic             Write_Reg_0;
    logic             Write_Reg_1;
    logic [DW-1:0]    W_Data_0;
    logic [DW-1:0]    W_Data_1;
    logic             Busy_Set;
    logic [AW-1:0]    Busy_Addr;

    reg_file_mp #(
        .DATA_W(DW), .ADDR_W(AW), .N_RD(NR),
        .ZERO_REG(1'b1), .BYPASS(1'b1)
    ) u_byp (
        .Clk(Clk), .Reset(Reset),
        .R_Addr(R_Addr), .R_Data(rdata_a), .R_Busy(rbusy_a),
        .W_Addr_0(W_Addr_0), .W_Addr_1(W_Addr_1),
        .Write_Reg_0(Write_Reg_0), .Write_Reg_1(Write_Reg_1),
        .W_Data_0(W_Data_0), .W_Data_1(W_Data_1),
        .Busy_Set(Busy_Set), .Busy_Addr(Busy_Addr)
    );

    reg_file_mp #(
        .DATA_W(DW), .ADDR_W(AW), .N_RD(NR),
        .ZERO_REG(1'b1), .BYPASS(1'b0)
    ) u_nbyp (
        .Clk(Clk), .Reset(Reset),
        .R_Addr(R_Addr), .R_Data(rdata_b), .R_Busy(rbusy_b),
        .W_Addr_0(W_Addr_0), .W_Addr_1(W_Addr_1),
        .Write_Reg_0(Write_Reg_0), .Write_Reg_1(Write_Reg_1),
        .W_Data_0(W_Data_0), .W_Data_1(W_Data_1),
        .Busy_Set(Busy_Set), .Busy_Addr(Busy_Addr)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        string       tag;
        bit          nb;
        int          port;
        logic [31:0] data;
        logic        busy;
    } exp_t;

    exp_t        sbq[$];
    int          n_chk;
    int          n_fail;
    logic [31:0] ref_mem[32];
    logic        ref_busy[32];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic exp_rd(input string tag, input bit nb, input int port,
                          input logic [31:0] d, input logic b);
        exp_t e;
        e.tag  = tag;
        e.nb   = nb;
        e.port = port;
        e.data = d;
        e.busy = b;
        sbq.push_back(e);
    endtask

    task automatic drain();
        exp_t        e;
        logic [31:0] gd;
        logic        gb;
        #2;
        while (sbq.size() > 0) begin
            e  = sbq.pop_front();
            gd = e.nb ? rdata_b[e.port*DW +: DW] : rdata_a[e.port*DW +: DW];
            gb = e.nb ? rbusy_b[e.port] : rbusy_a[e.port];
            chk({e.tag, "_d"}, gd, e.data);
            chk({e.tag, "_b"}, {31'b0, gb}, {31'b0, e.busy});
        end
    endtask

    task automatic model_edge();
        if (Reset) begin
            for (int i = 0; i < 32; i++) begin
                ref_mem[i]  = '0;
                ref_busy[i] = 1'b0;
            end
        end else begin
            if (Write_Reg_0 && W_Addr_0 != 0) begin
                ref_mem[W_Addr_0]  = W_Data_0;
                ref_busy[W_Addr_0] = 1'b0;
            end
            if (Write_Reg_1 && W_Addr_1 != 0) begin
                ref_mem[W_Addr_1]  = W_Data_1;
                ref_busy[W_Addr_1] = 1'b0;
            end
            if (Busy_Set && Busy_Addr != 0) ref_busy[Busy_Addr] = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        model_edge();
        #1;
    endtask

    function automatic logic [31:0] pred_d(input logic [4:0] a, input bit byp);
        if (a == 0) return '0;
        if (byp && Write_Reg_1 && W_Addr_1 == a) return W_Data_1;
        if (byp && Write_Reg_0 && W_Addr_0 == a) return W_Data_0;
        return ref_mem[a];
    endfunction

    function automatic logic pred_b(input logic [4:0] a, input bit byp);
        bit wr;
        if (a == 0) return 1'b0;
        wr = (Write_Reg_0 && W_Addr_0 == a) || (Write_Reg_1 && W_Addr_1 == a);
        if (byp && wr && !(Busy_Set && Busy_Addr == a)) return 1'b0;
        return ref_busy[a];
    endfunction

    task automatic idle();
        Write_Reg_0 = 1'b0;
        Write_Reg_1 = 1'b0;
        Busy_Set    = 1'b0;
    endtask

    task automatic set_rd(input int k, input logic [4:0] a);
        R_Addr[k*AW +: AW] = a;
    endtask

    task automatic wr0(input logic [4:0] a, input logic [31:0] d);
        Write_Reg_0 = 1'b1;
        W_Addr_0    = a;
        W_Data_0    = d;
    endtask

    task automatic wr1(input logic [4:0] a, input logic [31:0] d);
        Write_Reg_1 = 1'b1;
        W_Addr_1    = a;
        W_Data_1    = d;
    endtask

    task automatic bset(input logic [4:0] a);
        Busy_Set  = 1'b1;
        Busy_Addr = a;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        Reset  = 1'b1;
        R_Addr = '0;
        W_Addr_0 = '0;
        W_Addr_1 = '0;
        W_Data_0 = '0;
        W_Data_1 = '0;
        Busy_Addr = '0;
        idle();
        for (int i = 0; i < 32; i++) begin
            ref_mem[i]  = 'x;
            ref_busy[i] = 1'bx;
        end
        tick();
        Reset = 1'b0;
        for (int k = 0; k < NR; k++) set_rd(k, 5'(k + 1));
        for (int k = 0; k < NR; k++) begin
            exp_rd("rst", 0, k, 32'h0, 1'b0);
            exp_rd("rst_nb", 1, k, 32'h0, 1'b0);
        end
        drain();

        // dual write, then reset clears
        set_rd(0, 5'd1);
        set_rd(1, 5'd2);
        wr0(5'd1, 32'h1111_1111);
        wr1(5'd2, 32'h2222_2222);
        exp_rd("t1_byp0", 0, 0, 32'h1111_1111, 1'b0);
        exp_rd("t1_byp1", 0, 1, 32'h2222_2222, 1'b0);
        exp_rd("t1_old0", 1, 0, 32'h0, 1'b0);
        drain();
        tick();
        idle();
        exp_rd("t1_r1", 0, 0, 32'h1111_1111, 1'b0);
        exp_rd("t1_r2", 0, 1, 32'h2222_2222, 1'b0);
        exp_rd("t1_r1_nb", 1, 0, 32'h1111_1111, 1'b0);
        exp_rd("t1_r2_nb", 1, 1, 32'h2222_2222, 1'b0);
        drain();
        Reset = 1'b1;
        exp_rd("t1_inrst", 0, 0, 32'h1111_1111, 1'b0);
        drain();
        tick();
        Reset = 1'b0;
        exp_rd("t1_clr1", 0, 0, 32'h0, 1'b0);
        exp_rd("t1_clr2", 1, 1, 32'h0, 1'b0);
        drain();

        // same-address dual write: port 1 wins
        set_rd(0, 5'd5);
        wr0(5'd5, 32'hAAAA_0000);
        wr1(5'd5, 32'h5555_FFFF);
        exp_rd("t2_byp", 0, 0, 32'h5555_FFFF, 1'b0);
        drain();
        tick();
        idle();
        exp_rd("t2_r5", 0, 0, 32'h5555_FFFF, 1'b0);
        exp_rd("t2_r5_nb", 1, 0, 32'h5555_FFFF, 1'b0);
        drain();

        // register 0 hardwired
        set_rd(0, 5'd0);
        wr0(5'd0, 32'hDEAD_BEEF);
        wr1(5'd0, 32'hDEAD_BEEF);
        bset(5'd0);
        exp_rd("t3_wcyc", 0, 0, 32'h0, 1'b0);
        exp_rd("t3_wcyc_nb", 1, 0, 32'h0, 1'b0);
        drain();
        tick();
        idle();
        exp_rd("t3_after", 0, 0, 32'h0, 1'b0);
        exp_rd("t3_after_nb", 1, 0, 32'h0, 1'b0);
        drain();

        // bypass vs. storage-only read
        set_rd(0, 5'd7);
        wr0(5'd7, 32'hCAFE_F00D);
        tick();
        idle();
        wr0(5'd7, 32'h1234_5678);
        exp_rd("t4_byp", 0, 0, 32'h1234_5678, 1'b0);
        exp_rd("t4_old_nb", 1, 0, 32'hCAFE_F00D, 1'b0);
        drain();
        tick();
        idle();
        exp_rd("t4_new", 0, 0, 32'h1234_5678, 1'b0);
        exp_rd("t4_new_nb", 1, 0, 32'h1234_5678, 1'b0);
        drain();

        // busy scoreboard
        set_rd(0, 5'd3);
        bset(5'd3);
        exp_rd("t5_setcyc", 0, 0, 32'h0, 1'b0);
        drain();
        tick();
        idle();
        exp_rd("t5_busy", 0, 0, 32'h0, 1'b1);
        exp_rd("t5_busy_nb", 1, 0, 32'h0, 1'b1);
        drain();
        wr0(5'd3, 32'h3333_3333);
        exp_rd("t5_wcyc", 0, 0, 32'h3333_3333, 1'b0);
        exp_rd("t5_wcyc_nb", 1, 0, 32'h0, 1'b1);
        drain();
        tick();
        idle();
        exp_rd("t5_clr", 0, 0, 32'h3333_3333, 1'b0);
        exp_rd("t5_clr_nb", 1, 0, 32'h3333_3333, 1'b0);
        drain();
        wr0(5'd3, 32'h3333_AAAA);
        bset(5'd3);
        exp_rd("t5_wsetcyc", 0, 0, 32'h3333_AAAA, 1'b0);
        drain();
        tick();
        idle();
        exp_rd("t5_wset", 0, 0, 32'h3333_AAAA, 1'b1);
        exp_rd("t5_wset_nb", 1, 0, 32'h3333_AAAA, 1'b1);
        drain();

        // four independent read ports
        wr0(5'd1, 32'h1111_1111);
        wr1(5'd2, 32'h2222_2222);
        tick();
        idle();
        set_rd(0, 5'd1);
        set_rd(1, 5'd2);
        set_rd(2, 5'd3);
        set_rd(3, 5'd0);
        for (int nb = 0; nb < 2; nb++) begin
            exp_rd("t6_p0", nb[0], 0, 32'h1111_1111, 1'b0);
            exp_rd("t6_p1", nb[0], 1, 32'h2222_2222, 1'b0);
            exp_rd("t6_p2", nb[0], 2, 32'h3333_AAAA, 1'b1);
            exp_rd("t6_p3", nb[0], 3, 32'h0, 1'b0);
        end
        drain();

        // random traffic on a small address window for collisions
        for (int it = 0; it < 60; it++) begin
            Reset       = ($urandom_range(0, 15) == 0);
            Write_Reg_0 = 1'($urandom_range(0, 1));
            Write_Reg_1 = 1'($urandom_range(0, 1));
            Busy_Set    = 1'($urandom_range(0, 1));
            W_Addr_0    = 5'($urandom_range(0, 7));
            W_Addr_1    = 5'($urandom_range(0, 7));
            Busy_Addr   = 5'($urandom_range(0, 7));
            W_Data_0    = $urandom;
            W_Data_1    = $urandom;
            for (int k = 0; k < NR; k++) set_rd(k, 5'($urandom_range(0, 7)));
            for (int k = 0; k < NR; k++) begin
                exp_rd("rnd", 0, k, pred_d(R_Addr[k*AW +: AW], 1'b1),
                       pred_b(R_Addr[k*AW +: AW], 1'b1));
                exp_rd("rnd_nb", 1, k, pred_d(R_Addr[k*AW +: AW], 1'b0),
                       pred_b(R_Addr[k*AW +: AW], 1'b0));
            end
            drain();
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
